// File: rtl/divisor_subtrai_desloca.sv
// divisor_subtrai_desloca: sequential restoring (shift-subtract) unsigned divider.
// Computes an N-bit quotient and N-bit remainder of dividend / divisor in 2N+1 cycles.
// It uses a start/idle/done handshake and exposes the Moore control strobes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   st                  start request, sampled only in IDLE
//   dividend, divisor   operands, latched on the edge that leaves LOAD
//   quotient, remainder results, valid from DONE until the next LOAD
//   idle/load/sh/su/done one-hot state strobes (exactly one high per cycle)
//   dz                  divide-by-zero flag, valid with done
//
// Optional feature macro: DIVISOR_ZERO_DET_EN
//   When it is defined, a zero divisor is detected in LOAD and the unit jumps straight to DONE.
//   When it is undefined, dz is tied to 0.
module divisor_subtrai_desloca #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         idle,
    output logic         load,
    output logic         sh,
    output logic         su,
    output logic         done,
    output logic         dz
);

    localparam int unsigned KW = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_SUB,
        S_DONE
    } state_t;

    state_t        state, state_d;
    logic [N:0]    a, a_d;
    logic [N-1:0]  q, q_d;
    logic [N-1:0]  b, b_d;
    logic [KW-1:0] k, k_d;
    logic [N:0]    diff;
`ifdef DIVISOR_ZERO_DET_EN
    logic          dz_q, dz_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a     <= '0;
            q     <= '0;
            b     <= '0;
            k     <= '0;
`ifdef DIVISOR_ZERO_DET_EN
            dz_q  <= 1'b0;
`endif
        end else begin
            state <= state_d;
            a     <= a_d;
            q     <= q_d;
            b     <= b_d;
            k     <= k_d;
`ifdef DIVISOR_ZERO_DET_EN
            dz_q  <= dz_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state;
        a_d     = a;
        q_d     = q;
        b_d     = b;
        k_d     = k;
`ifdef DIVISOR_ZERO_DET_EN
        dz_d    = dz_q;
`endif
        // The sign bit of the (N+1)-bit difference indicates A < B, so the subtraction is skipped.
        diff    = a - {1'b0, b};

        case (state)
            S_IDLE: begin
                if (st) state_d = S_LOAD;
            end
            S_LOAD: begin
                a_d     = '0;
                q_d     = dividend;
                b_d     = divisor;
                k_d     = '0;
                state_d = S_SHIFT;
`ifdef DIVISOR_ZERO_DET_EN
                dz_d    = 1'b0;
                if (divisor == '0) begin
                    dz_d    = 1'b1;
                    q_d     = '1;
                    a_d     = {1'b0, dividend};
                    state_d = S_DONE;
                end
`endif
            end
            S_SHIFT: begin
                // A[N] is always 0 here because the partial remainder stays below B.
                {a_d, q_d} = {a[N-1:0], q, 1'b0};
                state_d    = S_SUB;
            end
            S_SUB: begin
                if (!diff[N]) begin
                    a_d    = diff;
                    q_d[0] = 1'b1;
                end
                if (k == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k + KW'(1);
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next-state decode, so they track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle <= 1'b1;
            load <= 1'b0;
            sh   <= 1'b0;
            su   <= 1'b0;
            done <= 1'b0;
        end else begin
            idle <= (state_d == S_IDLE);
            load <= (state_d == S_LOAD);
            sh   <= (state_d == S_SHIFT);
            su   <= (state_d == S_SUB);
            done <= (state_d == S_DONE);
        end
    end

    assign quotient  = q;
    assign remainder = a[N-1:0];
`ifdef DIVISOR_ZERO_DET_EN
    assign dz = dz_q;
`else
    assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_subtrai_desloca.sv
// Directed self-checking bench for divisor_subtrai_desloca (N = 8).
module tb_divisor_subtrai_desloca;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic         st;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         idle, load, sh, su, done, dz;

    int vectors;
    int miscompares;

    divisor_subtrai_desloca #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st        (st),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .idle      (idle),
        .load      (load),
        .sh        (sh),
        .su        (su),
        .done      (done),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) until the unit is idle, sampling on the falling edge.
    task automatic wait_idle();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (idle) return;
        end
        miscompares++;
        vectors++;
        $display("FAIL wait_idle: idle never returned");
    endtask

    // Start one operation and return the results plus the edge count from E0 to done (-1 = timeout).
    task automatic run_op(input logic [N-1:0] dd, input logic [N-1:0] dv,
                          output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic z, output int cyc);
        wait_idle();
        dividend = dd;
        divisor  = dv;
        st       = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = n;
                break;
            end
        end
        q = quotient;
        r = remainder;
        z = dz;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        st = 1'b0;
        dividend = '0;
        divisor = '0;
        #12;
        vectors++;
        if ({quotient, remainder} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_result: got q=%0d r=%0d want 0 0", quotient, remainder);
        end
        vectors++;
        if ({idle, load, sh, su, done, dz} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 100000", {idle, load, sh, su, done, dz});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // 100/7 with a check of every strobe cycle from E0 through the return to idle.
    task automatic test_strobe_order();
        logic [4:0] exp_s;
        wait_idle();
        dividend = 8'd100;
        divisor  = 8'd7;
        st       = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        for (int t = 0; t <= 18; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (t == 0) exp_s = 5'b01000;
            else if (t == 17) exp_s = 5'b00001;
            else if (t == 18) exp_s = 5'b10000;
            else if (t % 2 == 1) exp_s = 5'b00100;
            else exp_s = 5'b00010;
            vectors++;
            if ({idle, load, sh, su, done} !== exp_s) begin
                miscompares++;
                $display("FAIL strobe_t%0d: got %b want %b", t, {idle, load, sh, su, done}, exp_s);
            end
            if (t == 17) begin
                vectors++;
                if ({quotient, remainder, dz} !== {8'd14, 8'd2, 1'b0}) begin
                    miscompares++;
                    $display("FAIL div_100_7: got q=%0d r=%0d dz=%b want 14 2 0",
                             quotient, remainder, dz);
                end
            end
        end
    endtask

    task automatic test_vectors();
        logic [7:0] tdd [6] = '{8'd255, 8'd5, 8'd200, 8'd0, 8'd255, 8'd254};
        logic [7:0] tdv [6] = '{8'd1,   8'd9, 8'd200, 8'd5, 8'd16,  8'd255};
        logic [7:0] tq  [6] = '{8'd255, 8'd0, 8'd1,   8'd0, 8'd15,  8'd0};
        logic [7:0] tr  [6] = '{8'd0,   8'd5, 8'd0,   8'd0, 8'd15,  8'd254};
        logic [N-1:0] q, r;
        logic z;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            run_op(tdd[i], tdv[i], q, r, z, cyc);
            vectors++;
            if (cyc != 17) begin
                miscompares++;
                $display("FAIL latency_%0d: got %0d edges want 17", i, cyc);
            end
            vectors++;
            if ({q, r, z} !== {tq[i], tr[i], 1'b0}) begin
                miscompares++;
                $display("FAIL div_%0d_%0d: got q=%0d r=%0d dz=%b want %0d %0d 0",
                         tdd[i], tdv[i], q, r, z, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [N-1:0] q, r;
        logic z;
        int cyc;
        int exp_cyc;
        logic exp_dz;
`ifdef DIVISOR_ZERO_DET_EN
        exp_cyc = 1;
        exp_dz  = 1'b1;
`else
        exp_cyc = 17;
        exp_dz  = 1'b0;
`endif
        run_op(8'd37, 8'd0, q, r, z, cyc);
        vectors++;
        if (cyc != exp_cyc) begin
            miscompares++;
            $display("FAIL div0_latency: got %0d want %0d", cyc, exp_cyc);
        end
        vectors++;
        if ({q, r, z} !== {8'd255, 8'd37, exp_dz}) begin
            miscompares++;
            $display("FAIL div0_result: got q=%0d r=%0d dz=%b want 255 37 %b", q, r, z, exp_dz);
        end
    endtask

    // Inputs and st churn during SHIFT/SUB; the result must follow the operands latched at LOAD.
    task automatic test_input_noise();
        int cyc;
        bit restarted;
        wait_idle();
        dividend = 8'd200;
        divisor  = 8'd13;
        st       = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        cyc = -1;
        restarted = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (load) restarted = 1'b1;
            if (done) begin
                cyc = n;
                break;
            end
            st       = ~st;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
        end
        st = 1'b0;
        vectors++;
        if (cyc != 17 || restarted) begin
            miscompares++;
            $display("FAIL noise_timing: got done at %0d restart=%0b want 17 0", cyc, restarted);
        end
        vectors++;
        if ({quotient, remainder} !== {8'd15, 8'd5}) begin
            miscompares++;
            $display("FAIL noise_result: got q=%0d r=%0d want 15 5", quotient, remainder);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] q, r;
        logic z;
        int cyc;
        wait_idle();
        dividend = 8'd100;
        divisor  = 8'd7;
        st       = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({quotient, remainder, idle, load, sh, su, done, dz} !== {16'h0000, 6'b100000}) begin
            miscompares++;
            $display("FAIL reset_mid: got q=%0d r=%0d strobes=%b want 0 0 100000",
                     quotient, remainder, {idle, load, sh, su, done, dz});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd100, 8'd7, q, r, z, cyc);
        vectors++;
        if (cyc != 17 || {q, r} !== {8'd14, 8'd2}) begin
            miscompares++;
            $display("FAIL after_reset: got cyc=%0d q=%0d r=%0d want 17 14 2", cyc, q, r);
        end
    endtask

    task automatic test_back_to_back();
        int first_t, second_t, idle_cnt;
        logic [N-1:0] q1, r1;
        wait_idle();
        dividend = 8'd100;
        divisor  = 8'd7;
        st       = 1'b1;
        first_t  = -1;
        second_t = -1;
        idle_cnt = 0;
        q1 = '0;
        r1 = '0;
        for (int t = 1; t <= 80; t++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first_t < 0) begin
                    first_t = t;
                    q1 = quotient;
                    r1 = remainder;
                end else begin
                    second_t = t;
                    break;
                end
            end else if (idle && first_t >= 0) begin
                idle_cnt++;
            end
        end
        st = 1'b0;
        vectors++;
        if (first_t < 0 || second_t < 0 || second_t - first_t != 19) begin
            miscompares++;
            $display("FAIL b2b_spacing: got done at %0d and %0d want 19 apart", first_t, second_t);
        end
        vectors++;
        if (idle_cnt != 1) begin
            miscompares++;
            $display("FAIL b2b_idle: got %0d idle cycles want 1", idle_cnt);
        end
        vectors++;
        if ({q1, r1, quotient, remainder} !== {8'd14, 8'd2, 8'd14, 8'd2}) begin
            miscompares++;
            $display("FAIL b2b_result: got %0d/%0d and %0d/%0d want 14/2 twice",
                     q1, r1, quotient, remainder);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_strobe_order();
        test_vectors();
        test_div_zero();
        test_input_noise();
        test_reset_mid();
        test_back_to_back();
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
